led_frame_reader: RTL and testbench



---
 rtl/led_frame_pkg.sv | 16 +
 rtl/led_sync_fifo.sv | 48 ++++
 rtl/led_frame_reader.sv | 138 +++++++++++++
 tb/tb_led_frame_reader.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_frame_pkg.sv
// rtl/led_frame_pkg.sv - shared types and constants for the LED frame reader
package led_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_CNT_W      = 11;
  localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/led_sync_fifo.sv
// rtl/led_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module led_sync_fifo import led_frame_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   used
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pushes into a full FIFO and pops from an empty one are dropped.
  assign do_push = push & (used != (AW+1)'(DEPTH));
  assign do_pop  = pop & (used != '0);

  // Head entry is visible combinationally the cycle after it is written.
  assign head = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      used <= used + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage array; entries outside the valid window are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/led_frame_reader.sv
// rtl/led_frame_reader.sv - Avalon-MM block reader feeding an Avalon-ST pixel packet
module led_frame_reader import led_frame_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int UW = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] sent;
  logic [UW-1:0]    outstanding;
  logic [UW-1:0]    fifo_used;
  logic [31:0]      fifo_head;

  logic             accept;
  logic             resp;
  logic             pop;
  logic             last_beat;
  logic [CNT_W-1:0] issued_nxt;
  logic [UW-1:0]    outstanding_nxt;
  logic [UW-1:0]    used_nxt;
  logic [UW:0]      in_flight_nxt;
  logic             more_to_issue;
  logic             have_credit;

  assign m_byteenable = 4'hF;

  assign accept    = m_read & ~m_waitrequest;
  // Responses with nothing outstanding are leftovers from before a reset.
  assign resp      = m_readdatavalid & (outstanding != '0);
  assign st_valid  = (fifo_used != '0);
  assign pop       = st_valid & st_ready;
  assign st_data   = st_valid ? fifo_head : 32'h0;
  assign st_sop    = st_valid & (sent == '0);
  assign st_eop    = st_valid & (sent == count - CNT_W'(1));
  assign last_beat = pop & (sent == count - CNT_W'(1));

  led_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (resp),
    .push_data (m_readdata),
    .pop       (pop),
    .head      (fifo_head),
    .used      (fifo_used)
  );

  // Next-cycle occupancy: every word either in flight on the bus or parked in the FIFO holds a credit.
  always_comb begin
    issued_nxt      = issued + {{(CNT_W-1){1'b0}}, accept};
    outstanding_nxt = outstanding + {{(UW-1){1'b0}}, accept} - {{(UW-1){1'b0}}, resp};
    used_nxt        = fifo_used + {{(UW-1){1'b0}}, resp} - {{(UW-1){1'b0}}, pop};
    in_flight_nxt   = {1'b0, outstanding_nxt} + {1'b0, used_nxt};
    have_credit     = in_flight_nxt < (UW+1)'(FIFO_DEPTH);
    more_to_issue   = issued_nxt < count;
  end

  // Transfer FSM with counters and registered bus/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      issued      <= '0;
      sent        <= '0;
      outstanding <= '0;
      m_address   <= '0;
      m_read      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= outstanding_nxt;
      if (pop) sent <= sent + CNT_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              count     <= word_count;
              issued    <= '0;
              sent      <= '0;
              m_address <= base_addr & ~ADDR_W'(3);
              m_read    <= 1'b1;
              busy      <= 1'b1;
              state     <= READ;
            end else begin
              done <= 1'b1;
            end
          end
        end

        READ: begin
          issued <= issued_nxt;
          if (accept) m_address <= m_address + ADDR_W'(BYTES_PER_WORD);
          // While stalled, credits can only grow, so m_read and m_address hold.
          m_read <= more_to_issue & have_credit;
          if (accept && !more_to_issue) state <= DRAIN;
        end

        DRAIN: begin
          if (last_beat) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_reader.sv
// tb/tb_led_frame_reader.sv - directed bench for led_frame_reader
module tb_led_frame_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [10:0] word_count = '0;
  logic        busy, done;
  logic [11:0] m_address;
  logic        m_read;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b1;
  logic        st_sop, st_eop;

  logic        slave_rdv = 1'b0;
  logic [31:0] slave_data = '0;
  logic        inj_rdv = 1'b0;
  logic [31:0] inj_data = '0;
  bit          slave_en = 1'b1;

  assign m_readdatavalid = slave_rdv | inj_rdv;
  assign m_readdata      = inj_rdv ? inj_data : slave_data;

  led_frame_reader dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .word_count      (word_count),
    .busy            (busy),
    .done            (done),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .st_data         (st_data),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_sop          (st_sop),
    .st_eop          (st_eop)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [1024];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          addr_log[$];
  int          acc_cyc[$];
  logic [31:0] beat_data[$];
  bit          beat_sop[$];
  bit          beat_eop[$];
  int          stall_viol = 0;
  bit          prev_stall = 1'b0;
  logic [11:0] prev_addr = '0;

  // On-chip RAM slave model, read latency 1.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (slave_en && m_read && !m_waitrequest) begin
      slave_rdv  <= 1'b1;
      slave_data <= ram[m_address[11:2]];
    end else begin
      slave_rdv <= 1'b0;
    end
  end

  // Bus and stream logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(m_read && m_address == prev_addr)) stall_viol++;
      if (m_read && !m_waitrequest) begin
        addr_log.push_back(int'(m_address));
        acc_cyc.push_back(cyc);
      end
      if (st_valid && st_ready) begin
        beat_data.push_back(st_data);
        beat_sop.push_back(st_sop);
        beat_eop.push_back(st_eop);
      end
      prev_stall = m_read && m_waitrequest;
      prev_addr  = m_address;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    acc_cyc.delete();
    beat_data.delete();
    beat_sop.delete();
    beat_eop.delete();
    stall_viol = 0;
  endtask

  task automatic do_start(input logic [11:0] base, input logic [10:0] cnt);
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int budget, input bit rand_wait,
                           output int dcyc, output int first_v);
    dcyc    = -1;
    first_v = -1;
    for (int c = c0; c < c0 + budget; c++) begin
      if (st_valid && first_v < 0) first_v = c;
      if (done) begin
        dcyc = c;
        break;
      end
      if (rand_wait) m_waitrequest = 1'($urandom_range(0, 1));
      tick();
    end
    m_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({m_address, st_data, m_read, busy, done, st_valid, st_sop, st_eop, m_byteenable} !==
        {12'h000, 32'h0, 6'b000000, 4'hF}) begin
      miscompares++;
      $display("FAIL reset_outputs got addr=%h data=%h rd=%b busy=%b done=%b v=%b sop=%b eop=%b be=%h want 000/0/0/0/0/0/0/0/f",
               m_address, st_data, m_read, busy, done, st_valid, st_sop, st_eop, m_byteenable);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int dcyc, first_v;
    int exp_addr[4] = '{12'h010, 12'h014, 12'h018, 12'h01C};
    clear_logs();
    do_start(12'h010, 11'd4);
    vectors++;
    if ({busy, m_read, m_address} !== {1'b1, 1'b1, 12'h010}) begin
      miscompares++;
      $display("FAIL basic_cycle1 got busy=%b rd=%b addr=%h want 1 1 010", busy, m_read, m_address);
    end
    wait_done(1, 100, 1'b0, dcyc, first_v);
    vectors++;
    if (first_v != 3) begin
      miscompares++;
      $display("FAIL basic_first_valid got cycle %0d want 3", first_v);
    end
    vectors++;
    if (dcyc != 7 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done got cycle %0d busy=%b want cycle 7 busy=0", dcyc, busy);
    end
    vectors++;
    if (addr_log.size() != 4) begin
      miscompares++;
      $display("FAIL basic_addr_count got %0d want 4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (addr_log[i] != exp_addr[i] || acc_cyc[i] != acc_cyc[0] + i) begin
          miscompares++;
          $display("FAIL basic_addr[%0d] got %h at +%0d want %h at +%0d",
                   i, addr_log[i], acc_cyc[i] - acc_cyc[0], exp_addr[i], i);
        end
      end
    end
    vectors++;
    if (beat_data.size() != 4) begin
      miscompares++;
      $display("FAIL basic_beat_count got %0d want 4", beat_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if ({beat_data[i], beat_sop[i], beat_eop[i]} !== {32'hA0 + 32'(i), i == 0, i == 3}) begin
          miscompares++;
          $display("FAIL basic_beat[%0d] got %h sop=%b eop=%b want %h sop=%b eop=%b",
                   i, beat_data[i], beat_sop[i], beat_eop[i], 32'hA0 + 32'(i), i == 0, i == 3);
        end
      end
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_pulse got done=%b one cycle later want 0", done);
    end
  endtask

  task automatic test_single();
    int dcyc, first_v;
    clear_logs();
    do_start(12'h020, 11'd1);
    wait_done(1, 100, 1'b0, dcyc, first_v);
    vectors++;
    if (dcyc != 4) begin
      miscompares++;
      $display("FAIL single_done got cycle %0d want 4", dcyc);
    end
    vectors++;
    if (beat_data.size() != 1) begin
      miscompares++;
      $display("FAIL single_beat_count got %0d want 1", beat_data.size());
    end else if ({beat_data[0], beat_sop[0], beat_eop[0]} !== {32'h5A, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_beat got %h sop=%b eop=%b want 0000005a sop=1 eop=1",
               beat_data[0], beat_sop[0], beat_eop[0]);
    end
    tick();
  endtask

  task automatic test_zero();
    clear_logs();
    do_start(12'h040, 11'd0);
    vectors++;
    if ({done, busy, m_read} !== 3'b100) begin
      miscompares++;
      $display("FAIL zero_cycle1 got done=%b busy=%b rd=%b want 1 0 0", done, busy, m_read);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done_pulse got %b want 0", done);
    end
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (addr_log.size() != 0 || beat_data.size() != 0) begin
      miscompares++;
      $display("FAIL zero_activity got %0d reads %0d beats want 0 0", addr_log.size(), beat_data.size());
    end
  endtask

  task automatic test_backpressure();
    int dcyc, first_v;
    clear_logs();
    st_ready = 1'b0;
    do_start(12'h100, 11'd16);
    for (int i = 0; i < 19; i++) tick();
    vectors++;
    if (addr_log.size() != 8 || m_read !== 1'b0 || st_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_credit_stop got %0d reads rd=%b v=%b want 8 reads rd=0 v=1",
               addr_log.size(), m_read, st_valid);
    end
    st_ready = 1'b1;
    wait_done(20, 200, 1'b0, dcyc, first_v);
    vectors++;
    if (dcyc < 0 || beat_data.size() != 16) begin
      miscompares++;
      $display("FAIL bp_complete got done_cycle=%0d beats=%0d want done and 16 beats", dcyc, beat_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if ({beat_data[i], beat_sop[i], beat_eop[i]} !== {32'hC000_0040 + 32'(i), i == 0, i == 15}) begin
          miscompares++;
          $display("FAIL bp_beat[%0d] got %h sop=%b eop=%b want %h", i, beat_data[i], beat_sop[i],
                   beat_eop[i], 32'hC000_0040 + 32'(i));
        end
      end
    end
    tick();
  endtask

  task automatic test_waitrequest();
    int dcyc, first_v, bad;
    clear_logs();
    do_start(12'h200, 11'd32);
    wait_done(1, 1000, 1'b1, dcyc, first_v);
    vectors++;
    if (dcyc < 0 || stall_viol != 0) begin
      miscompares++;
      $display("FAIL wait_stability got done_cycle=%0d violations=%0d want done and 0", dcyc, stall_viol);
    end
    bad = 0;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != 12'h200 + 4 * i) bad++;
    vectors++;
    if (addr_log.size() != 32 || bad != 0) begin
      miscompares++;
      $display("FAIL wait_addrs got %0d reads %0d wrong want 32 reads 0 wrong", addr_log.size(), bad);
    end
    bad = 0;
    for (int i = 0; i < beat_data.size(); i++)
      if ({beat_data[i], beat_sop[i], beat_eop[i]} !== {32'hC000_0080 + 32'(i), i == 0, i == 31}) bad++;
    vectors++;
    if (beat_data.size() != 32 || bad != 0) begin
      miscompares++;
      $display("FAIL wait_beats got %0d beats %0d wrong want 32 beats 0 wrong", beat_data.size(), bad);
    end
    tick();
  endtask

  task automatic test_wrap();
    int dcyc, first_v;
    int exp_addr[4]      = '{12'hFF8, 12'hFFC, 12'h000, 12'h004};
    logic [31:0] exp_d[4] = '{32'hC000_03FE, 32'hC000_03FF, 32'hC000_0000, 32'hC000_0001};
    clear_logs();
    do_start(12'hFF8, 11'd4);
    wait_done(1, 100, 1'b0, dcyc, first_v);
    vectors++;
    if (addr_log.size() != 4 || beat_data.size() != 4) begin
      miscompares++;
      $display("FAIL wrap_counts got %0d reads %0d beats want 4 4", addr_log.size(), beat_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (addr_log[i] != exp_addr[i] || beat_data[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL wrap[%0d] got addr %h data %h want %h %h", i, addr_log[i], beat_data[i],
                   exp_addr[i], exp_d[i]);
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dcyc, first_v;
    clear_logs();
    slave_en = 1'b0;
    do_start(12'h040, 11'd8);
    tick();
    tick();
    tick();
    m_waitrequest = 1'b1;
    reset = 1'b1;
    tick();
    vectors++;
    if (addr_log.size() != 3) begin
      miscompares++;
      $display("FAIL rmid_outstanding got %0d accepted want 3", addr_log.size());
    end
    vectors++;
    if ({m_address, st_data, m_read, busy, done, st_valid, st_sop, st_eop} !== {12'h000, 32'h0, 6'b000000}) begin
      miscompares++;
      $display("FAIL rmid_outputs got addr=%h data=%h rd=%b busy=%b done=%b v=%b want all 0",
               m_address, st_data, m_read, busy, done, st_valid);
    end
    reset = 1'b0;
    m_waitrequest = 1'b0;
    inj_data = 32'hDEAD_BEEF;
    inj_rdv = 1'b1;
    tick();
    tick();
    tick();
    inj_rdv = 1'b0;
    tick();
    tick();
    vectors++;
    if (st_valid !== 1'b0 || beat_data.size() != 0) begin
      miscompares++;
      $display("FAIL rmid_stale got v=%b beats=%0d want 0 0", st_valid, beat_data.size());
    end
    slave_en = 1'b1;
    clear_logs();
    do_start(12'h010, 11'd4);
    wait_done(1, 100, 1'b0, dcyc, first_v);
    vectors++;
    if (dcyc != 7 || beat_data.size() != 4) begin
      miscompares++;
      $display("FAIL rmid_restart got done_cycle=%0d beats=%0d want 7 4", dcyc, beat_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (beat_data[i] !== 32'hA0 + 32'(i)) begin
          miscompares++;
          $display("FAIL rmid_beat[%0d] got %h want %h", i, beat_data[i], 32'hA0 + 32'(i));
        end
      end
    end
    tick();
  endtask

  initial begin
    for (int w = 0; w < 1024; w++) ram[w] = 32'hC000_0000 + 32'(w);
    for (int w = 0; w < 4; w++) ram[4 + w] = 32'hA0 + 32'(w);
    ram[8] = 32'h5A;
    test_reset();
    test_basic();
    test_single();
    test_zero();
    test_backpressure();
    test_waitrequest();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
